// File: rtl/thread_pc_sequencer_pkg.sv
// Shared types for the barrel-thread PC sequencer: sequencer state and
// the next-PC source select.
package thread_pc_pkg;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } seq_state_e;

  typedef enum logic [1:0] {
    PC_SEL_INC    = 2'd0,
    PC_SEL_HOLD   = 2'd1,
    PC_SEL_BRANCH = 2'd2,
    PC_SEL_WRITE  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/thread_pc_sequencer_if.sv
// Feedback / ALU-write inputs and issued-PC outputs of the thread PC sequencer.
interface thread_pc_sequencer_if #(
  parameter int PC_WIDTH          = 10,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int D_OPERAND_WIDTH   = 10,
  parameter int WORD_WIDTH        = 36
);
  logic [PC_WIDTH-1:0]          branch_destination;
  logic                         jump;
  logic                         cancel;
  logic [D_OPERAND_WIDTH-1:0]   ALU_write_addr;
  logic [WORD_WIDTH-1:0]        ALU_write_data;
  logic [PC_WIDTH-1:0]          PC;
  logic [THREAD_ADDR_WIDTH-1:0] current_thread;
  logic                         pc_issue_valid;

  modport master (
    output branch_destination, jump, cancel, ALU_write_addr, ALU_write_data,
    input  PC, current_thread, pc_issue_valid
  );

  modport slave (
    input  branch_destination, jump, cancel, ALU_write_addr, ALU_write_data,
    output PC, current_thread, pc_issue_valid
  );
endinterface

// File: rtl/thread_pc_sequencer_slot_counter.sv
// thread_slot_counter: round-robin slot thread counter plus the warmup
// cycle counter that tells the sequencer when the PC loop is primed.
module thread_slot_counter #(
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int INITIAL_THREAD    = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         warm_en,
  output logic [THREAD_ADDR_WIDTH-1:0] slot_thread,
  output logic                         warm_last
);
  localparam logic [THREAD_ADDR_WIDTH-1:0] LAST = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);

  logic [THREAD_ADDR_WIDTH-1:0] slot_q, slot_d;
  logic [THREAD_ADDR_WIDTH-1:0] warm_q, warm_d;

  assign slot_thread = slot_q;
  assign warm_last   = (warm_q == LAST);

  always_comb begin
    slot_d = (slot_q == LAST) ? '0 : slot_q + 1'b1;
    warm_d = warm_q;
    if (warm_en) warm_d = warm_last ? '0 : warm_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= THREAD_ADDR_WIDTH'(INITIAL_THREAD);
      warm_q <= '0;
    end else begin
      slot_q <= slot_d;
      warm_q <= warm_d;
    end
  end
endmodule

// File: rtl/thread_pc_sequencer.sv
// Barrel-thread PC sequencer: one PC per cycle, round-robin over threads.
// Define THREAD_PC_WRITE_EN to enable the memory-mapped per-thread PC write.
module thread_pc_sequencer
  import thread_pc_pkg::*;
#(
  parameter int PC_WIDTH           = 10,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_ADDR_WIDTH  = 3,
  parameter int INITIAL_THREAD     = 0,
  parameter int START_PC           = 0,
  parameter int PC_WRITE_ADDR_BASE = 0,
  parameter int D_OPERAND_WIDTH    = 10,
  parameter int WORD_WIDTH         = 36
) (
  input  logic                  clock,
  input  logic                  reset_n,
  thread_pc_sequencer_if.slave  bus
);
  logic [THREAD_ADDR_WIDTH-1:0] slot_thread;
  logic                         warm_last;
  seq_state_e                   state_q, state_d;
  pc_sel_e                      pc_sel;

  logic [PC_WIDTH-1:0]          pc_mem_q [THREAD_COUNT];
  logic [PC_WIDTH-1:0]          pc_mem_d [THREAD_COUNT];
  logic [PC_WIDTH-1:0]          cur_pc, next_pc, pc_q;
  logic [THREAD_ADDR_WIDTH-1:0] thread_q;
  logic                         valid_q;

  logic                         wr_hit;
  logic [THREAD_ADDR_WIDTH-1:0] wr_idx;
  logic [PC_WIDTH-1:0]          wr_data;

  thread_slot_counter #(
    .THREAD_COUNT      (THREAD_COUNT),
    .THREAD_ADDR_WIDTH (THREAD_ADDR_WIDTH),
    .INITIAL_THREAD    (INITIAL_THREAD)
  ) u_slot_counter (
    .clock       (clock),
    .reset_n     (reset_n),
    .warm_en     (state_q == ST_WARMUP),
    .slot_thread (slot_thread),
    .warm_last   (warm_last)
  );

`ifdef THREAD_PC_WRITE_EN
  // One extra bit so an address below the base shows up as a borrow.
  logic [D_OPERAND_WIDTH:0] wr_off;
  logic                     unused_wr_data;
  assign wr_off  = {1'b0, bus.ALU_write_addr} - (D_OPERAND_WIDTH + 1)'(PC_WRITE_ADDR_BASE);
  assign wr_hit  = !wr_off[D_OPERAND_WIDTH] &&
                   (wr_off[D_OPERAND_WIDTH-1:0] < D_OPERAND_WIDTH'(THREAD_COUNT));
  assign wr_idx  = wr_off[THREAD_ADDR_WIDTH-1:0];
  assign wr_data = bus.ALU_write_data[PC_WIDTH-1:0];
  assign unused_wr_data = ^bus.ALU_write_data[WORD_WIDTH-1:PC_WIDTH];
`else
  logic unused_alu_write;
  assign wr_hit  = 1'b0;
  assign wr_idx  = '0;
  assign wr_data = '0;
  assign unused_alu_write = ^{bus.ALU_write_addr, bus.ALU_write_data};
`endif

  assign cur_pc = pc_mem_q[slot_thread];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_WARMUP;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_WARMUP && warm_last) state_d = ST_RUN;
  end

  // During warmup the feedback inputs carry nothing meaningful, so hold.
  always_comb begin
    pc_sel = PC_SEL_HOLD;
    if (state_q == ST_RUN) begin
      if (wr_hit && wr_idx == slot_thread) pc_sel = PC_SEL_WRITE;
      else if (bus.jump)                   pc_sel = PC_SEL_BRANCH;
      else if (bus.cancel)                 pc_sel = PC_SEL_HOLD;
      else                                 pc_sel = PC_SEL_INC;
    end
    case (pc_sel)
      PC_SEL_INC:    next_pc = cur_pc + 1'b1;
      PC_SEL_BRANCH: next_pc = bus.branch_destination;
      PC_SEL_WRITE:  next_pc = wr_data;
      default:       next_pc = cur_pc;
    endcase
  end

  always_comb begin
    pc_mem_d = pc_mem_q;
    pc_mem_d[slot_thread] = next_pc;
    if (wr_hit) pc_mem_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < THREAD_COUNT; i++) pc_mem_q[i] <= PC_WIDTH'(START_PC);
      pc_q     <= PC_WIDTH'(START_PC);
      thread_q <= THREAD_ADDR_WIDTH'(INITIAL_THREAD);
      valid_q  <= 1'b0;
    end else begin
      pc_mem_q <= pc_mem_d;
      pc_q     <= next_pc;
      thread_q <= slot_thread;
      valid_q  <= (state_q == ST_RUN);
    end
  end

  assign bus.PC             = pc_q;
  assign bus.current_thread = thread_q;
  assign bus.pc_issue_valid = valid_q;
endmodule

// File: tb/tb_thread_pc_sequencer.sv
// Scoreboard bench for thread_pc_sequencer: a driver pushes expected issue
// values per cycle, a monitor pops and compares one cycle later.
module tb_thread_pc_sequencer;
  localparam int PCW  = 10;
  localparam int TC   = 8;
  localparam int TAW  = 3;
  localparam int DW   = 10;
  localparam int WW   = 36;
  localparam int BASE = 0;
  localparam logic [DW-1:0] IDLE_ADDR = 10'h3FF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  thread_pc_sequencer_if #(
    .PC_WIDTH(PCW), .THREAD_ADDR_WIDTH(TAW), .D_OPERAND_WIDTH(DW), .WORD_WIDTH(WW)
  ) bus ();

  thread_pc_sequencer #(
    .PC_WIDTH(PCW), .THREAD_COUNT(TC), .THREAD_ADDR_WIDTH(TAW), .INITIAL_THREAD(0),
    .START_PC(0), .PC_WRITE_ADDR_BASE(BASE), .D_OPERAND_WIDTH(DW), .WORD_WIDTH(WW)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [TAW-1:0] thr;
    logic           vld;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  logic [PCW-1:0] mmem [TC];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, ".pc"},  32'(bus.PC),             32'(e.pc));
        check({nm, ".thr"}, 32'(bus.current_thread), 32'(e.thr));
        check({nm, ".vld"}, 32'(bus.pc_issue_valid), 32'(e.vld));
      end
    end
  end

  // hand >= 0 gives the hand-computed PC; thread/valid follow the slot schedule.
  task automatic step(input bit rn, input bit j, input bit c, input logic [PCW-1:0] dest,
                      input logic [DW-1:0] wa, input logic [WW-1:0] wd,
                      input int hand, input string nm);
    int             t;
    int             k;
    bit             run;
    logic [PCW-1:0] np;
    exp_t           e;
    @(posedge clk);
    #2;
    rst_n                  = rn;
    bus.jump               = j;
    bus.cancel             = c;
    bus.branch_destination = dest;
    bus.ALU_write_addr     = wa;
    bus.ALU_write_data     = wd;
    if (!rn) begin
      cyc = 0;
      for (int i = 0; i < TC; i++) mmem[i] = '0;
      e = '0;
    end else begin
      t   = cyc % TC;
      run = (cyc >= TC);
      k   = -1;
`ifdef THREAD_PC_WRITE_EN
      if (int'(wa) >= BASE && int'(wa) - BASE < TC) k = int'(wa) - BASE;
`endif
      np = mmem[t];
      if (run) begin
        if (k == t)  np = wd[PCW-1:0];
        else if (j)  np = dest;
        else if (!c) np = mmem[t] + 1'b1;
      end
      mmem[t] = np;
      if (k >= 0) mmem[k] = wd[PCW-1:0];
      e.pc  = (hand >= 0) ? PCW'(hand) : np;
      e.thr = TAW'(t);
      e.vld = run;
      cyc++;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input int hand, input string nm);
    step(1'b1, 1'b0, 1'b0, '0, IDLE_ADDR, '0, hand, nm);
  endtask

  initial begin : driver
    bus.jump = 1'b0; bus.cancel = 1'b0; bus.branch_destination = '0;
    bus.ALU_write_addr = IDLE_ADDR; bus.ALU_write_data = '0;

    step(1'b0, 1'b0, 1'b0, '0, IDLE_ADDR, '0, 0, "reset0");
    step(1'b0, 1'b0, 1'b0, '0, IDLE_ADDR, '0, 0, "reset1");
    // Feedback asserted during warmup must be ignored.
    for (int i = 0; i < TC; i++)
      step(1'b1, 1'b1, 1'b1, 10'h2AA, IDLE_ADDR, '0, 0, $sformatf("warm.t%0d", i));
    for (int i = 0; i < TC; i++) idle(1, $sformatf("r1.t%0d", i));
    for (int i = 0; i < TC; i++)
      case (i)
        3:       step(1'b1, 1'b1, 1'b0, 10'h155, IDLE_ADDR, '0, 'h155, "r2.t3.jump");
        5:       step(1'b1, 1'b0, 1'b1, '0, IDLE_ADDR, '0, 1, "r2.t5.cancel");
        default: idle(2, $sformatf("r2.t%0d", i));
      endcase
    for (int i = 0; i < TC; i++)
      case (i)
        2:       step(1'b1, 1'b1, 1'b0, 10'h3FF, IDLE_ADDR, '0, 'h3FF, "r3.t2.jump");
        3:       idle('h156, "r3.t3");
        5:       step(1'b1, 1'b1, 1'b0, 10'h020, IDLE_ADDR, '0, 'h020, "r3.t5.jump");
        default: idle(3, $sformatf("r3.t%0d", i));
      endcase
    for (int i = 0; i < TC; i++)
      case (i)
        2:       idle('h000, "r4.t2.wrap");
        3:       idle('h157, "r4.t3");
        5:       step(1'b1, 1'b0, 1'b1, '0, IDLE_ADDR, '0, 'h020, "r4.t5.cancel");
        default: idle(4, $sformatf("r4.t%0d", i));
      endcase
    for (int i = 0; i < TC; i++)
      case (i)
        2:       idle('h001, "r5.t2");
        3:       idle('h158, "r5.t3");
        5:       step(1'b1, 1'b1, 1'b1, 10'h040, IDLE_ADDR, '0, 'h040, "r5.t5.jmpcan");
`ifdef THREAD_PC_WRITE_EN
        6:       step(1'b1, 1'b1, 1'b0, 10'h2AA, DW'(BASE + 6), 36'hABCDEF100, 'h100, "r5.t6.wr");
        7:       step(1'b1, 1'b0, 1'b0, '0, DW'(BASE + 1), 36'h5555550AB, 5, "r5.t7.wr1");
`else
        6:       step(1'b1, 1'b1, 1'b0, 10'h2AA, DW'(BASE + 6), 36'hABCDEF100, 'h2AA, "r5.t6.jump");
        7:       step(1'b1, 1'b0, 1'b0, '0, DW'(BASE + 1), 36'h5555550AB, 5, "r5.t7");
`endif
        default: idle(5, $sformatf("r5.t%0d", i));
      endcase
    for (int i = 0; i < TC; i++)
      case (i)
`ifdef THREAD_PC_WRITE_EN
        1:       idle('h0AC, "r6.t1");
        6:       idle('h101, "r6.t6");
`else
        1:       idle(6, "r6.t1");
        6:       idle('h2AB, "r6.t6");
`endif
        2:       idle('h002, "r6.t2");
        3:       idle('h159, "r6.t3");
        5:       idle('h041, "r6.t5");
        default: idle(6, $sformatf("r6.t%0d", i));
      endcase
    // One-cycle reset mid-RUN with feedback pending, then a full warmup again.
    step(1'b0, 1'b1, 1'b0, 10'h155, IDLE_ADDR, '0, 0, "midrst");
    for (int i = 0; i < TC; i++) idle(0, $sformatf("rewarm.t%0d", i));
    for (int i = 0; i < 3; i++) idle(1, $sformatf("rerun.t%0d", i));

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #5;
    n_cmp++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
